// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
//   Types and constants shared by the encoder position/speed tracking logic
//   and by anything that consumes encoder_reader step/polarity pulses.
//   No ports.
// ----------------------------------------------------------------------------
package encoder_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    TRACKING = 2'd2,
    STALLED  = 2'd3
  } tracker_state_t;

  // Polarity level that means a forward (+1) step.
  localparam logic POL_FWD = 1'b1;

endpackage : encoder_pkg

// File: rtl/speed_window_counter.sv
// ----------------------------------------------------------------------------
// speed_window_counter
//   Counts signed steps over a programmable window of clock cycles and
//   publishes the saturated count as a speed sample at the end of each window.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_run          1 = window running; 0 = counter and accumulator forced to 0
//   i_step         accepted step this cycle (already gated by the caller)
//   i_polarity     step direction, POL_FWD = +1
//   i_window_len   window length in cycles, sampled at window start; 0 = off
//   o_speed        signed step count of the last completed window, saturated
//   o_speed_valid  one-cycle pulse when o_speed takes a new value
// ----------------------------------------------------------------------------
module speed_window_counter
  import encoder_pkg::*;
#(
  parameter int SPD_W = 16,
  parameter int WIN_W = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_polarity,
  input  logic [WIN_W-1:0]        i_window_len,
  output logic signed [SPD_W-1:0] o_speed,
  output logic                    o_speed_valid
);

  localparam int ACC_W = SPD_W + 1;

  localparam logic [WIN_W-1:0]        WIN_ONE = WIN_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {SPD_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {SPD_W{1'b0}}};

  // Speed is symmetric: +/-(2^(SPD_W-1)-1), the most negative code is unused.
  localparam logic signed [SPD_W-1:0] SPD_MAX     = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W-1:0] SPD_MIN     = {1'b1, {(SPD_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] SPD_MAX_EXT = {2'b00, {(SPD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SPD_MIN_EXT = {2'b11, {(SPD_W-2){1'b0}}, 1'b1};

  logic [WIN_W-1:0]        cnt_q, cnt_d;
  logic [WIN_W-1:0]        len_q, len_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SPD_W-1:0] speed_q, speed_d;
  logic                    valid_q, valid_d;

  logic [WIN_W-1:0]        eff_len;
  logic signed [ACC_W-1:0] acc_inc;

  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    speed_d = speed_q;
    valid_d = 1'b0;

    // The live length is only looked at on the first cycle of a window;
    // afterwards the latched copy governs, so reprogramming mid-window is safe.
    eff_len = (cnt_q == '0) ? i_window_len : len_q;

    // Accumulator clamps at its own range so a very long window cannot wrap
    // and flip the sign of the reported speed.
    acc_inc = acc_q;
    if (i_step) begin
      if (i_polarity == POL_FWD) begin
        if (acc_q != ACC_MAX) acc_inc = acc_q + ACC_ONE;
      end else begin
        if (acc_q != ACC_MIN) acc_inc = acc_q - ACC_ONE;
      end
    end

    if (!i_run || (eff_len == '0)) begin
      cnt_d = '0;
      len_d = '0;
      acc_d = '0;
    end else if (cnt_q == (eff_len - WIN_ONE)) begin
      if (acc_inc > SPD_MAX_EXT) begin
        speed_d = SPD_MAX;
      end else if (acc_inc < SPD_MIN_EXT) begin
        speed_d = SPD_MIN;
      end else begin
        speed_d = acc_inc[SPD_W-1:0];
      end
      valid_d = 1'b1;
      cnt_d   = '0;
      len_d   = eff_len;
      acc_d   = '0;
    end else begin
      cnt_d = cnt_q + WIN_ONE;
      len_d = eff_len;
      acc_d = acc_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
    end
  end

  assign o_speed       = speed_q;
  assign o_speed_valid = valid_q;

endmodule : speed_window_counter

// File: rtl/encoder_position_tracker.sv
// ----------------------------------------------------------------------------
// encoder_position_tracker
//   Turns encoder step/polarity pulses into a wrapping signed position, a
//   windowed speed measurement and a stall indication.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DISABLED | tracking off; steps ignored, window/stall counters at 0
//   ARMED    | enabled, waiting for the first step
//   TRACKING | steps arriving; stall counter measures idle time
//   STALLED  | no step for i_stall_limit cycles; next step resumes
//
// Ports
//   i_clk / i_rst         clock, synchronous active-high reset
//   i_enable              1 = run tracking, 0 = force DISABLED
//   i_step / i_polarity   one-cycle step pulse and its direction
//   i_clear_pos           position <= 0 (highest priority)
//   i_preset_valid        position <= i_preset_value
//   i_window_len          speed window length in cycles, 0 = off
//   i_stall_limit         idle cycles before stall, 0 = off
//   o_position            signed wrapping position
//   o_speed/_valid        last window's step count and its update pulse
//   o_stalled             1 while STALLED
//   o_state               current state
// ----------------------------------------------------------------------------
module encoder_position_tracker
  import encoder_pkg::*;
#(
  parameter int POS_W   = 32,
  parameter int SPD_W   = 16,
  parameter int WIN_W   = 24,
  parameter int STALL_W = 24
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_step,
  input  logic                    i_polarity,
  input  logic                    i_clear_pos,
  input  logic                    i_preset_valid,
  input  logic signed [POS_W-1:0] i_preset_value,
  input  logic [WIN_W-1:0]        i_window_len,
  input  logic [STALL_W-1:0]      i_stall_limit,
  output logic signed [POS_W-1:0] o_position,
  output logic signed [SPD_W-1:0] o_speed,
  output logic                    o_speed_valid,
  output logic                    o_stalled,
  output tracker_state_t          o_state
);

  localparam logic signed [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [STALL_W-1:0]      STALL_ONE = STALL_W'(1);

  tracker_state_t          state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic [STALL_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                    stalled_q, stalled_d;

  logic active;
  logic step_acc;
  logic stall_fire;

  // A cycle with i_enable low is already treated as disabled so that the
  // window cannot complete or count on the way out.
  assign active   = i_enable && (state_q != DISABLED);
  assign step_acc = active && i_step;

  assign stall_fire = (i_stall_limit != '0) && (stall_cnt_q == (i_stall_limit - STALL_ONE));

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = '0;

    if (!i_enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = ARMED;
        ARMED: begin
          if (i_step) state_d = TRACKING;
        end
        TRACKING: begin
          // A step on the would-be stall cycle keeps us tracking.
          if (i_step) begin
            stall_cnt_d = '0;
          end else if (stall_fire) begin
            state_d = STALLED;
          end else begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
          end
        end
        STALLED: begin
          if (i_step) state_d = TRACKING;
        end
        default: state_d = DISABLED;
      endcase
    end

    stalled_d = (state_d == STALLED);

    // Clear and preset override a coincident step, which is then lost.
    if (i_clear_pos) begin
      pos_d = '0;
    end else if (i_preset_valid) begin
      pos_d = i_preset_value;
    end else if (step_acc) begin
      pos_d = (i_polarity == POL_FWD) ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= DISABLED;
      pos_q       <= '0;
      stall_cnt_q <= '0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      stall_cnt_q <= stall_cnt_d;
      stalled_q   <= stalled_d;
    end
  end

  speed_window_counter #(
    .SPD_W (SPD_W),
    .WIN_W (WIN_W)
  ) u_speed_window_counter (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_run         (active),
    .i_step        (step_acc),
    .i_polarity    (i_polarity),
    .i_window_len  (i_window_len),
    .o_speed       (o_speed),
    .o_speed_valid (o_speed_valid)
  );

  assign o_position = pos_q;
  assign o_stalled  = stalled_q;
  assign o_state    = state_q;

endmodule : encoder_position_tracker

// File: tb/tb_encoder_position_tracker.sv
// ----------------------------------------------------------------------------
// tb_encoder_position_tracker
//   Drives directed and random step traffic into encoder_position_tracker
//   (SPD_W = 4 so speed saturation is reachable) and compares against a
//   behavioural model. Expected per-cycle snapshots and expected speed
//   samples are queued by the driver and consumed by an independent monitor.
// ----------------------------------------------------------------------------
module tb_encoder_position_tracker;
  import encoder_pkg::*;

  localparam int POS_W   = 32;
  localparam int SPD_W   = 4;
  localparam int WIN_W   = 24;
  localparam int STALL_W = 24;
  localparam int SMAX    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    step = 1'b0;
  logic                    pol = 1'b1;
  logic                    clr = 1'b0;
  logic                    pre_v = 1'b0;
  logic [POS_W-1:0]        pre_val = '0;
  logic [WIN_W-1:0]        win_len = '0;
  logic [STALL_W-1:0]      stall_lim = '0;

  logic [POS_W-1:0]        o_position;
  logic signed [SPD_W-1:0] o_speed;
  logic                    o_speed_valid;
  logic                    o_stalled;
  tracker_state_t          o_state;

  encoder_position_tracker #(
    .POS_W   (POS_W),
    .SPD_W   (SPD_W),
    .WIN_W   (WIN_W),
    .STALL_W (STALL_W)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (en),
    .i_step         (step),
    .i_polarity     (pol),
    .i_clear_pos    (clr),
    .i_preset_valid (pre_v),
    .i_preset_value (pre_val),
    .i_window_len   (win_len),
    .i_stall_limit  (stall_lim),
    .o_position     (o_position),
    .o_speed        (o_speed),
    .o_speed_valid  (o_speed_valid),
    .o_stalled      (o_stalled),
    .o_state        (o_state)
  );

  typedef struct {
    logic [POS_W-1:0] pos;
    tracker_state_t   st;
    logic             stalled;
    logic             valid;
    int               speed;
  } snap_t;

  snap_t snap_q[$];
  int    spd_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    valid_seen = 0;

  // Behavioural model: position, state, idle time, current window contents.
  tracker_state_t   m_st = DISABLED;
  logic [POS_W-1:0] m_pos = '0;
  int               m_idle = 0;
  int               m_age = 0;
  int               m_sum = 0;
  int               m_len = 0;
  int               m_speed = 0;
  bit               m_valid = 1'b0;
  bit               m_stalled = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_speed(input int v);
    if (v > SMAX) return SMAX;
    if (v < -SMAX) return -SMAX;
    return v;
  endfunction

  task automatic model_step();
    int             d;
    bit             act;
    tracker_state_t nst;
    snap_t          s;
    if (rst) begin
      m_st = DISABLED; m_pos = '0; m_idle = 0; m_age = 0; m_sum = 0;
      m_len = 0; m_speed = 0; m_valid = 1'b0; m_stalled = 1'b0;
    end else begin
      d   = pol ? 1 : -1;
      act = en && (m_st != DISABLED);

      if (clr) m_pos = '0;
      else if (pre_v) m_pos = pre_val;
      else if (act && step) m_pos = m_pos + POS_W'(d);

      m_valid = 1'b0;
      if (!act) begin
        m_age = 0; m_sum = 0;
      end else begin
        if (m_age == 0) m_len = int'(win_len);
        if (m_len == 0) begin
          m_age = 0; m_sum = 0;
        end else begin
          if (step) m_sum += d;
          if (m_age == m_len - 1) begin
            m_speed = clamp_speed(m_sum);
            m_valid = 1'b1;
            spd_q.push_back(m_speed);
            m_age = 0; m_sum = 0;
          end else begin
            m_age++;
          end
        end
      end

      nst = m_st;
      if (!en) begin
        nst = DISABLED; m_idle = 0;
      end else begin
        case (m_st)
          DISABLED: nst = ARMED;
          ARMED:    if (step) nst = TRACKING;
          TRACKING: begin
            if (step) m_idle = 0;
            else if (stall_lim != 0 && m_idle == int'(stall_lim) - 1) begin
              nst = STALLED; m_idle = 0;
            end else m_idle++;
          end
          STALLED:  if (step) nst = TRACKING;
          default:  nst = DISABLED;
        endcase
      end
      m_st = nst;
      m_stalled = (nst == STALLED);
    end
    s.pos = m_pos; s.st = m_st; s.stalled = m_stalled; s.valid = m_valid; s.speed = m_speed;
    snap_q.push_back(s);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    step = 1'b0; clr = 1'b0; pre_v = 1'b0; rst = 1'b0;
  endtask

  snap_t mon_s;
  int    mon_e;
  always @(negedge clk) begin
    if (snap_q.size() > 0) begin
      mon_s = snap_q.pop_front();
      check("position", o_position, mon_s.pos);
      check("state", o_state, mon_s.st);
      check("stalled", o_stalled, mon_s.stalled);
      check("speed_valid", o_speed_valid, mon_s.valid);
      check("speed_held", o_speed, mon_s.speed);
    end
    if (o_speed_valid === 1'b1) begin
      valid_seen++;
      if (spd_q.size() == 0) begin
        check("unexpected_speed_valid", 1, 0);
      end else begin
        mon_e = spd_q.pop_front();
        check("speed_sample", o_speed, mon_e);
      end
    end
  end

  initial begin
    int v0;
    logic [POS_W-1:0] p0;
    int prob;
    int pol_bias;

    rst = 1'b1; cycle();
    rst = 1'b1; cycle();
    check("reset_state", o_state, DISABLED);
    check("reset_pos", o_position, 0);

    // Window of 10 with 4 forward steps.
    win_len = 10; stall_lim = 0; en = 1'b1; pol = 1'b1;
    cycle();
    check("t1_armed", o_state, ARMED);
    for (int i = 0; i < 10; i++) begin
      step = (i % 2 == 1) && (i < 8);
      cycle();
    end
    check("t1_speed", o_speed, 4);
    check("t1_valid", o_speed_valid, 1);
    check("t1_pos", o_position, 4);
    en = 1'b0; cycle();

    // Preset to max positive, wrap by one step, then step lost to clear.
    en = 1'b1; pre_val = 32'h7FFF_FFFF; pre_v = 1'b1; cycle();
    step = 1'b1; pol = 1'b1; cycle();
    check("t2_wrap", o_position, 64'h8000_0000);
    step = 1'b1; clr = 1'b1; cycle();
    check("t2_clear_beats_step", o_position, 0);
    en = 1'b0; cycle();

    // Twelve reverse steps in a window of 20 saturate at -7.
    win_len = 20; en = 1'b1; cycle();
    v0 = valid_seen;
    for (int i = 0; i < 20; i++) begin
      step = (i < 12); pol = 1'b0;
      cycle();
    end
    check("t3_speed_sat", o_speed, -7);
    check("t3_valid", o_speed_valid, 1);
    pol = 1'b1; en = 1'b0; cycle();
    check("t3_valid_count", valid_seen - v0, 1);

    // Stall after 5 idle cycles, recover, and step exactly on stall cycle.
    win_len = 0; stall_lim = 5; en = 1'b1; cycle();
    step = 1'b1; cycle();
    for (int i = 0; i < 4; i++) cycle();
    check("t4_not_yet_stalled", o_stalled, 0);
    cycle();
    check("t4_stalled", o_stalled, 1);
    check("t4_state_stalled", o_state, STALLED);
    step = 1'b1; cycle();
    check("t4_resume", o_state, TRACKING);
    check("t4_resume_flag", o_stalled, 0);
    for (int i = 0; i < 4; i++) cycle();
    step = 1'b1; cycle();
    check("t4_step_on_stall_cycle", o_state, TRACKING);
    cycle();
    check("t4_no_stall", o_stalled, 0);
    en = 1'b0; cycle();

    // Drop enable mid-window: no sample, position frozen, re-enable arms.
    win_len = 10; stall_lim = 0; en = 1'b1; cycle();
    p0 = m_pos;
    for (int i = 0; i < 5; i++) begin step = 1'b1; cycle(); end
    v0 = valid_seen;
    en = 1'b0; cycle();
    check("t5_disabled", o_state, DISABLED);
    for (int i = 0; i < 10; i++) begin step = 1'b1; cycle(); end
    check("t5_pos_held", o_position, p0 + 5);
    check("t5_no_valid", valid_seen - v0, 0);
    en = 1'b1; cycle();
    check("t5_rearmed", o_state, ARMED);

    // Reset in the middle of a window with position 37.
    pre_val = 37; pre_v = 1'b1; cycle();
    step = 1'b1; cycle();
    pre_val = 37; pre_v = 1'b1; cycle();
    check("t6_pos_before", o_position, 37);
    rst = 1'b1; cycle();
    check("t6_pos", o_position, 0);
    check("t6_state", o_state, DISABLED);
    check("t6_speed", o_speed, 0);
    check("t6_valid", o_speed_valid, 0);
    check("t6_stalled", o_stalled, 0);

    // Random segments; configuration only changes while disabled.
    for (int seg = 0; seg < 30; seg++) begin
      en = 1'b0; cycle();
      win_len = WIN_W'($urandom_range(0, 15));
      if (win_len == 0) stall_lim = STALL_W'($urandom_range(0, 10));
      else if ($urandom_range(0, 3) == 0) stall_lim = '0;
      else stall_lim = STALL_W'(int'(win_len) + $urandom_range(0, 8));
      case ($urandom_range(0, 2))
        0: prob = 2;
        1: prob = 5;
        default: prob = 12;
      endcase
      pol_bias = $urandom_range(0, 100);
      en = 1'b1;
      for (int c = 0; c < 60; c++) begin
        step = ($urandom_range(1, prob) == 1);
        pol  = ($urandom_range(0, 99) < pol_bias);
        clr  = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 49) == 0) begin
          pre_v = 1'b1; pre_val = $urandom;
        end
        en  = ($urandom_range(0, 79) != 0);
        rst = ($urandom_range(0, 199) == 0);
        cycle();
      end
    end

    en = 1'b0; cycle(); cycle();
    @(negedge clk); #1;
    check("speed_queue_drained", spd_q.size(), 0);
    check("snapshot_queue_drained", snap_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_encoder_position_tracker
